pc_redirect_controller: RTL and testbench
=========================================

Name: pc_redirect_controller

Overview:
- Owns the fetch PC register and sequences every change of control flow: sequential PC+4, taken branch, J/JAL jump and JR/JALR register jump.
- Arbitrates simultaneous redirect requests from ID and EX and buffers a redirect that arrives while the pipeline is stalled.
- After each redirect, drives a multi-cycle flush to the IF/ID and ID/EX stages.
- Sits between the hazard unit, the ID jump decode, the EX branch/JR resolution and the instruction-memory address port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of cycles Flush is held after a redirect is applied (legal range 1..7).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Stall  input  1  hazard-unit stall; PC and controller state hold while high.
- Branch_Taken  input  1  EX-stage branch resolved taken.
- Branch_Target  input  32  EX-stage branch target.
- Jump_Register  input  1  EX-stage JR/JALR.
- Jump_Register_Addr  input  32  register-file value for JR/JALR.
- Jump  input  1  ID-stage J/JAL.
- Jump_Target  input  32  ID-stage jump target.
- PC  output  32  current fetch address (registered).
- PC_Source  output  2  source of the current PC: 0 = sequential, 1 = branch, 2 = jump, 3 = JR (registered).
- Flush  output  1  squash IF/ID and ID/EX contents.
- Redirect_Pending  output  1  a redirect is buffered behind a stall.
- Misaligned_Target  output  1  one-cycle pulse when an applied target had bits [1:0] != 0.

Behaviour:
- Reset (synchronous, reset high at a rising edge):
  - PC = RESET_PC, PC_Source = 0, Flush = 0, Redirect_Pending = 0, Misaligned_Target = 0.
  - State = RUN, flush counter = 0, hold register = 0.
  - Reset overrides all other inputs, including mid-flush and mid-hold.
- States:
  - RUN, HOLD and FLUSH.
  - Encoding: 2 bits. The flush counter is $clog2(FLUSH_CYCLES+1) bits wide.
- Redirect request priority (EX is older than ID):
  - Branch_Taken > Jump_Register > Jump.
  - The winning target has bits [1:0] forced to 0 before it is loaded. If the original bits were nonzero, Misaligned_Target pulses in the cycle the PC loads.
- RUN, Stall = 0:
  - No request: PC <= PC + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), PC_Source <= 0.
  - Request present: PC <= target and PC_Source <= source code in the next cycle, then FLUSH with counter = FLUSH_CYCLES.
  - Flush is high starting the cycle after the request edge. Redirect latency is 1 cycle.
- RUN, Stall = 1:
  - PC holds.
  - Request present: latch target and source into the hold register, set Redirect_Pending = 1, go to HOLD.
- HOLD:
  - Inputs Branch_Taken, Jump_Register and Jump are ignored; the buffered redirect wins.
  - While Stall = 1: everything holds.
  - On the first Stall = 0 edge: PC <= hold target, Redirect_Pending <= 0, then FLUSH with counter = FLUSH_CYCLES.
- FLUSH:
  - Flush = 1 while counter != 0.
  - Each non-stalled edge: PC <= PC + 4 and counter decrements. While Stall = 1, PC and counter freeze.
  - All redirect requests are ignored because they come from squashed instructions.
  - When the counter reaches 0, return to RUN; Flush is low that cycle.
- Flush is a registered output. Its total high time is exactly FLUSH_CYCLES non-stalled cycles plus any stalled cycles in between.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - PC_Source codes (PCSRC_SEQ = 0, PCSRC_BRANCH = 1, PCSRC_JUMP = 2, PCSRC_JR = 3).
  - Controller state encoding (ST_RUN, ST_HOLD, ST_FLUSH).
  - PC_INCREMENT = 4.
- One natural sub-module: pc_target_select. It is purely combinational: priority encode, alignment masking and the misalign flag, producing a valid/target/source triple.
- The FSM, counter and registers live in the top module.

Test Plan:
- Reset, then 4 idle cycles -> PC = 0, 4, 8, 12, 16; PC_Source = 0; Flush = 0.
- At PC = 0x10, Branch_Taken = 1 with Branch_Target = 0x100 and Jump = 1 with Jump_Target = 0x200 in the same cycle -> next PC = 0x100, PC_Source = 1, Flush high for exactly 2 cycles, PC = 0x104, 0x108; the Jump is never applied.
- Stall = 1 for 3 cycles; Jump_Register = 1 with Jump_Register_Addr = 0x3000 in the first stall cycle -> PC held, Redirect_Pending = 1; the cycle after Stall drops, PC = 0x3000, PC_Source = 3, Redirect_Pending = 0, Flush starts.
- During FLUSH, assert Jump with target 0x500 and Stall for 1 cycle -> Jump ignored, counter frozen, Flush high for 3 cycles total, PC does not advance in the stall cycle.
- Jump_Target = 0x0000_0206 -> PC = 0x204, Misaligned_Target pulses 1 cycle; PC at 0xFFFF_FFFC with no request -> next PC = 0x0.
- Assert reset in the middle of HOLD and again in the middle of FLUSH -> next cycle PC = RESET_PC, Flush = 0, Redirect_Pending = 0, state RUN.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-flow definitions: PC source codes, redirect controller
// state encoding and the word-alignment helper.
package cpu_ctrl_pkg;

   localparam logic [1:0] PCSRC_SEQ    = 2'd0;
   localparam logic [1:0] PCSRC_BRANCH = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_JR     = 2'd3;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_HOLD  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam logic [31:0] PC_INCREMENT = 32'd4;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_target_select.sv
// Combinational redirect arbiter: EX requests beat ID requests, the winning
// target is word-aligned and any dropped low bits are flagged.
module pc_target_select
   import cpu_ctrl_pkg::*;
(
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   input  logic        i_jump_register,
   input  logic [31:0] i_jump_register_addr,
   input  logic        i_jump,
   input  logic [31:0] i_jump_target,
   output logic        o_valid,
   output logic [31:0] o_target,
   output logic [1:0]  o_source,
   output logic        o_misaligned
);

   logic [31:0] w_raw;

   // Priority encode the three redirect sources
   always_comb begin
      o_valid  = 1'b0;
      w_raw    = 32'd0;
      o_source = PCSRC_SEQ;
      if (i_branch_taken) begin
         o_valid  = 1'b1;
         w_raw    = i_branch_target;
         o_source = PCSRC_BRANCH;
      end else if (i_jump_register) begin
         o_valid  = 1'b1;
         w_raw    = i_jump_register_addr;
         o_source = PCSRC_JR;
      end else if (i_jump) begin
         o_valid  = 1'b1;
         w_raw    = i_jump_target;
         o_source = PCSRC_JUMP;
      end else begin
         o_valid  = 1'b0;
         w_raw    = 32'd0;
         o_source = PCSRC_SEQ;
      end
   end

   assign o_target     = align_word(w_raw);
   assign o_misaligned = o_valid & (w_raw[1:0] != 2'b00);

endmodule

// File: rtl/pc_redirect_controller.sv
// Fetch PC owner: sequential advance, prioritised redirects, redirect
// buffering behind stalls, and a counted flush after every redirect.
module pc_redirect_controller
   import cpu_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          FLUSH_CYCLES = 2
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic        Branch_Taken,
   input  logic [31:0] Branch_Target,
   input  logic        Jump_Register,
   input  logic [31:0] Jump_Register_Addr,
   input  logic        Jump,
   input  logic [31:0] Jump_Target,
   output logic [31:0] PC,
   output logic [1:0]  PC_Source,
   output logic        Flush,
   output logic        Redirect_Pending,
   output logic        Misaligned_Target
);

   localparam int CW = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          w_valid;
   logic [31:0]   w_target;
   logic [1:0]    w_source;
   logic          w_misaligned;

   logic [31:0]   r_pc;
   logic [1:0]    r_pc_src;
   logic          r_flush;
   logic          r_pending;
   logic          r_misaligned;
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_hold_target;
   logic [1:0]    r_hold_src;
   logic          r_hold_mis;

   pc_target_select u_sel (
      .i_branch_taken       (Branch_Taken),
      .i_branch_target      (Branch_Target),
      .i_jump_register      (Jump_Register),
      .i_jump_register_addr (Jump_Register_Addr),
      .i_jump               (Jump),
      .i_jump_target        (Jump_Target),
      .o_valid              (w_valid),
      .o_target             (w_target),
      .o_source             (w_source),
      .o_misaligned         (w_misaligned)
   );

   // PC, controller state, flush counter and hold register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_pc_src      <= PCSRC_SEQ;
         r_flush       <= 1'b0;
         r_pending     <= 1'b0;
         r_misaligned  <= 1'b0;
         r_state       <= ST_RUN;
         r_cnt         <= '0;
         r_hold_target <= 32'd0;
         r_hold_src    <= PCSRC_SEQ;
         r_hold_mis    <= 1'b0;
      end else begin
         r_misaligned <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (!Stall) begin
                  if (w_valid) begin
                     r_pc         <= w_target;
                     r_pc_src     <= w_source;
                     r_misaligned <= w_misaligned;
                     r_flush      <= 1'b1;
                     r_cnt        <= CNT_LOAD;
                     r_state      <= ST_FLUSH;
                  end else begin
                     r_pc     <= r_pc + PC_INCREMENT;
                     r_pc_src <= PCSRC_SEQ;
                  end
               end else if (w_valid) begin
                  r_hold_target <= w_target;
                  r_hold_src    <= w_source;
                  r_hold_mis    <= w_misaligned;
                  r_pending     <= 1'b1;
                  r_state       <= ST_HOLD;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            // New requests are ignored here: the buffered one is older
            ST_HOLD: begin
               if (!Stall) begin
                  r_pc         <= r_hold_target;
                  r_pc_src     <= r_hold_src;
                  r_misaligned <= r_hold_mis;
                  r_pending    <= 1'b0;
                  r_flush      <= 1'b1;
                  r_cnt        <= CNT_LOAD;
                  r_state      <= ST_FLUSH;
               end else begin
                  r_state <= ST_HOLD;
               end
            end
            ST_FLUSH: begin
               if (!Stall) begin
                  r_pc     <= r_pc + PC_INCREMENT;
                  r_pc_src <= PCSRC_SEQ;
                  r_cnt    <= r_cnt - CNT_ONE;
                  r_flush  <= (r_cnt != CNT_ONE);
                  r_state  <= (r_cnt == CNT_ONE) ? ST_RUN : ST_FLUSH;
               end else begin
                  r_state <= ST_FLUSH;
               end
            end
            default: begin
               r_state   <= ST_RUN;
               r_flush   <= 1'b0;
               r_pending <= 1'b0;
               r_cnt     <= '0;
            end
         endcase
      end
   end

   assign PC                = r_pc;
   assign PC_Source         = r_pc_src;
   assign Flush             = r_flush;
   assign Redirect_Pending  = r_pending;
   assign Misaligned_Target = r_misaligned;

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Bench for pc_redirect_controller: directed scenarios plus randomized
// traffic, all compared against a rule-level reference model.
module tb_pc_redirect_controller;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          FC       = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Stall = 1'b0;
   logic        Branch_Taken = 1'b0;
   logic [31:0] Branch_Target = 32'd0;
   logic        Jump_Register = 1'b0;
   logic [31:0] Jump_Register_Addr = 32'd0;
   logic        Jump = 1'b0;
   logic [31:0] Jump_Target = 32'd0;
   logic [31:0] PC;
   logic [1:0]  PC_Source;
   logic        Flush;
   logic        Redirect_Pending;
   logic        Misaligned_Target;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] m_pc;
   logic [1:0]  m_src;
   int          m_flush_left;
   logic        m_pend;
   logic [31:0] m_pend_tgt;
   logic [1:0]  m_pend_src;
   logic        m_mis;

   pc_redirect_controller #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FC)) dut (
      .clk                (clk),
      .reset              (reset),
      .Stall              (Stall),
      .Branch_Taken       (Branch_Taken),
      .Branch_Target      (Branch_Target),
      .Jump_Register      (Jump_Register),
      .Jump_Register_Addr (Jump_Register_Addr),
      .Jump               (Jump),
      .Jump_Target        (Jump_Target),
      .PC                 (PC),
      .PC_Source          (PC_Source),
      .Flush              (Flush),
      .Redirect_Pending   (Redirect_Pending),
      .Misaligned_Target  (Misaligned_Target)
   );

   always #5 clk = ~clk;

   wire [36:0] act_vec = {PC, PC_Source, Flush, Redirect_Pending, Misaligned_Target};

   function automatic logic [36:0] exp_vec();
      return {m_pc, m_src, (m_flush_left != 0), m_pend, m_mis};
   endfunction

   // One rising edge; the model applies the controller rules to the inputs present at that edge
   task automatic tick();
      logic        req;
      logic [31:0] t;
      logic [1:0]  s;
      @(posedge clk);
      m_mis = 1'b0;
      req = Branch_Taken | Jump_Register | Jump;
      t = Branch_Taken ? Branch_Target : (Jump_Register ? Jump_Register_Addr : Jump_Target);
      s = Branch_Taken ? 2'd1 : (Jump_Register ? 2'd3 : 2'd2);
      if (reset) begin
         m_pc = RESET_PC; m_src = 2'd0; m_flush_left = 0; m_pend = 1'b0;
         m_pend_tgt = 32'd0; m_pend_src = 2'd0;
      end else if (m_flush_left > 0) begin
         if (!Stall) begin
            m_pc = m_pc + 32'd4; m_src = 2'd0; m_flush_left = m_flush_left - 1;
         end
      end else if (m_pend) begin
         if (!Stall) begin
            m_pc = m_pend_tgt & ~32'd3; m_src = m_pend_src;
            m_mis = (m_pend_tgt % 4) != 0; m_pend = 1'b0; m_flush_left = FC;
         end
      end else if (!Stall) begin
         if (req) begin
            m_pc = t & ~32'd3; m_src = s; m_mis = (t % 4) != 0; m_flush_left = FC;
         end else begin
            m_pc = m_pc + 32'd4; m_src = 2'd0;
         end
      end else if (req) begin
         m_pend = 1'b1; m_pend_tgt = t; m_pend_src = s;
      end
      #1;
   endtask

   task automatic clear_reqs();
      Branch_Taken = 1'b0; Jump_Register = 1'b0; Jump = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      n_checks++;
      if (act_vec !== {RESET_PC, 2'd0, 1'b0, 1'b0, 1'b0})
         $display("FAIL reset_state: got %h expected %h", act_vec, {RESET_PC, 5'd0});
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_idle();
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks++;
         if (PC !== 32'(4 * i) || PC_Source !== 2'd0 || Flush !== 1'b0)
            $display("FAIL idle_seq%0d: got pc=%h src=%0d flush=%b expected pc=%h src=0 flush=0",
                     i, PC, PC_Source, Flush, 32'(4 * i));
         else n_pass++;
      end
   endtask

   task automatic test_priority();
      int flush_hi;
      logic [31:0] exp_pc [3];
      logic [1:0]  exp_src [3];
      exp_pc  = '{32'h100, 32'h104, 32'h108};
      exp_src = '{2'd1, 2'd0, 2'd0};
      flush_hi = 0;
      Branch_Taken = 1'b1; Branch_Target = 32'h100; Jump = 1'b1; Jump_Target = 32'h200;
      tick();
      clear_reqs();
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         if (Flush === 1'b1) flush_hi++;
         n_checks++;
         if (PC !== exp_pc[i] || PC_Source !== exp_src[i] || act_vec !== exp_vec())
            $display("FAIL priority_step%0d: got %h expected %h (pc %h)", i, act_vec, exp_vec(), exp_pc[i]);
         else n_pass++;
      end
      n_checks++;
      if (flush_hi != FC) $display("FAIL priority_flush_len: got %0d expected %0d", flush_hi, FC);
      else n_pass++;
   endtask

   task automatic test_hold();
      logic [31:0] pc0;
      pc0 = PC;
      Stall = 1'b1; Jump_Register = 1'b1; Jump_Register_Addr = 32'h3000;
      for (int i = 0; i < 3; i++) begin
         tick();
         clear_reqs();
         Branch_Taken = (i == 1);
         Branch_Target = 32'h700;
         n_checks++;
         if (PC !== pc0 || Redirect_Pending !== 1'b1 || act_vec !== exp_vec())
            $display("FAIL hold_stall%0d: got %h expected %h", i, act_vec, exp_vec());
         else n_pass++;
      end
      clear_reqs();
      Stall = 1'b0;
      tick();
      n_checks++;
      if (PC !== 32'h3000 || PC_Source !== 2'd3 || Redirect_Pending !== 1'b0 || Flush !== 1'b1)
         $display("FAIL hold_release: got pc=%h src=%0d pend=%b flush=%b expected pc=00003000 src=3 pend=0 flush=1",
                  PC, PC_Source, Redirect_Pending, Flush);
      else n_pass++;
   endtask

   task automatic test_flush_stall();
      int flush_hi;
      flush_hi = 1;
      Stall = 1'b1; Jump = 1'b1; Jump_Target = 32'h500;
      tick();
      Stall = 1'b0;
      n_checks++;
      if (PC !== 32'h3000 || Flush !== 1'b1) $display("FAIL flush_freeze: got pc=%h flush=%b expected pc=00003000 flush=1", PC, Flush);
      else n_pass++;
      if (Flush === 1'b1) flush_hi++;
      tick();
      clear_reqs();
      if (Flush === 1'b1) flush_hi++;
      n_checks++;
      if (PC !== 32'h3004 || act_vec !== exp_vec()) $display("FAIL flush_ignore_jump: got %h expected %h", act_vec, exp_vec());
      else n_pass++;
      tick();
      if (Flush === 1'b1) flush_hi++;
      n_checks++;
      if (flush_hi != 3 || PC !== 32'h3008) $display("FAIL flush_total: got high=%0d pc=%h expected high=3 pc=00003008", flush_hi, PC);
      else n_pass++;
   endtask

   task automatic test_misalign_wrap();
      Jump = 1'b1; Jump_Target = 32'h0000_0206;
      tick();
      clear_reqs();
      n_checks++;
      if (PC !== 32'h204 || PC_Source !== 2'd2 || Misaligned_Target !== 1'b1)
         $display("FAIL misalign_load: got pc=%h src=%0d mis=%b expected pc=00000204 src=2 mis=1", PC, PC_Source, Misaligned_Target);
      else n_pass++;
      tick();
      n_checks++;
      if (Misaligned_Target !== 1'b0 || PC !== 32'h208) $display("FAIL misalign_pulse: got mis=%b pc=%h expected mis=0 pc=00000208", Misaligned_Target, PC);
      else n_pass++;
      tick();
      Jump = 1'b1; Jump_Target = 32'hFFFF_FFF4;
      tick();
      clear_reqs();
      tick(); tick();
      n_checks++;
      if (PC !== 32'hFFFF_FFFC || Flush !== 1'b0) $display("FAIL wrap_pre: got pc=%h flush=%b expected pc=fffffffc flush=0", PC, Flush);
      else n_pass++;
      tick();
      n_checks++;
      if (PC !== 32'h0 || PC_Source !== 2'd0) $display("FAIL wrap: got pc=%h src=%0d expected pc=00000000 src=0", PC, PC_Source);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      Stall = 1'b1; Branch_Taken = 1'b1; Branch_Target = 32'h40;
      tick();
      clear_reqs();
      reset = 1'b1;
      tick();
      reset = 1'b0; Stall = 1'b0;
      n_checks++;
      if (act_vec !== {RESET_PC, 5'd0}) $display("FAIL reset_in_hold: got %h expected %h", act_vec, {RESET_PC, 5'd0});
      else n_pass++;
      tick();
      n_checks++;
      if (PC !== RESET_PC + 32'd4 || Flush !== 1'b0) $display("FAIL after_hold_reset: got pc=%h flush=%b expected pc=%h flush=0", PC, Flush, RESET_PC + 32'd4);
      else n_pass++;
      Jump = 1'b1; Jump_Target = 32'h80;
      tick();
      clear_reqs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (act_vec !== {RESET_PC, 5'd0}) $display("FAIL reset_in_flush: got %h expected %h", act_vec, {RESET_PC, 5'd0});
      else n_pass++;
      tick();
      n_checks++;
      if (PC !== RESET_PC + 32'd4 || Flush !== 1'b0) $display("FAIL after_flush_reset: got pc=%h flush=%b expected pc=%h flush=0", PC, Flush, RESET_PC + 32'd4);
      else n_pass++;
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         reset              = ($urandom_range(0, 49) == 0);
         Stall              = ($urandom_range(0, 3) == 0);
         Branch_Taken       = ($urandom_range(0, 6) == 0);
         Jump_Register      = ($urandom_range(0, 6) == 0);
         Jump               = ($urandom_range(0, 5) == 0);
         Branch_Target      = $urandom;
         Jump_Register_Addr = $urandom;
         Jump_Target        = $urandom;
         tick();
         n_checks++;
         if (act_vec !== exp_vec()) begin
            errs++;
            if (errs <= 10) $display("FAIL random_cycle%0d: got %h expected %h", i, act_vec, exp_vec());
         end else n_pass++;
      end
      reset = 1'b0; Stall = 1'b0;
      clear_reqs();
   endtask

   initial begin
      test_reset();
      test_idle();
      test_priority();
      test_hold();
      test_flush_stall();
      test_misalign_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
